// File: rtl/gpio_pkg.sv
// Shared register indices and reset constants for the gpio_irq port.
package gpio_pkg;

  typedef logic [2:0] gpio_reg_t;

  localparam gpio_reg_t GPIO_TRIS  = 3'd0;
  localparam gpio_reg_t GPIO_OGPIO = 3'd1;
  localparam gpio_reg_t GPIO_IGPIO = 3'd2;
  localparam gpio_reg_t GPIO_OSET  = 3'd3;
  localparam gpio_reg_t GPIO_OCLR  = 3'd4;
  localparam gpio_reg_t GPIO_IE    = 3'd5;
  localparam gpio_reg_t GPIO_IPOL  = 3'd6;
  localparam gpio_reg_t GPIO_IFLAG = 3'd7;

  // Every pin comes out of reset as an input, so no pad is driven.
  localparam logic [31:0] GPIO_TRIS_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pad synchroniser plus a one-cycle-delayed copy for edge detection.
// The delayed stage exists only when GPIO_IRQ_EN is defined.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_pad,
  output logic [WIDTH-1:0] o_s1
`ifdef GPIO_IRQ_EN
  ,
  output logic [WIDTH-1:0] o_prev
`endif
);

  logic [WIDTH-1:0] r_s0;
  logic [WIDTH-1:0] r_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else begin
      r_s0 <= i_pad;
      r_s1 <= r_s0;
    end
  end

  assign o_s1 = r_s1;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= r_s1;
    end
  end

  assign o_prev = r_prev;
`endif

endmodule

// File: rtl/gpio_irq.sv
// Byte-lane GPIO port with direction, atomic set/clear and edge interrupts.
// Interrupt logic (IE/IPOL/IFLAG, edge detect, irq) exists only with GPIO_IRQ_EN.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         ADDR_LSB  = 0,
  parameter logic [7:0] BASE_ADDR = 8'h80
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic             wr_en,
  input  logic             rd_en,
  inout  wire  [WIDTH-1:0] port,
  output logic             irq
);

  localparam int         NBYTES   = WIDTH / 8;
  localparam int         BSEL     = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int         WIN_BITS = ADDR_LSB + 3 + BSEL;
  localparam logic [7:0] WIN_MASK = 8'((1 << WIN_BITS) - 1);

  logic             w_hit;
  gpio_reg_t        w_reg;
  logic [1:0]       w_lane;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_wbits;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_rd_word;
  logic [7:0]       w_rd_byte;

  logic [WIDTH-1:0] r_tris;
  logic [WIDTH-1:0] r_ogpio;
  logic [7:0]       r_dout;

  assign w_hit = (addr & ~WIN_MASK) == BASE_ADDR;
  assign w_reg = addr[ADDR_LSB+2:ADDR_LSB];

  if (BSEL > 0) begin : g_lane
    assign w_lane = 2'(addr[ADDR_LSB+3 +: BSEL]);
  end else begin : g_lane_single
    assign w_lane = 2'd0;
  end

  // A simultaneous read is dropped in favour of the write.
  assign w_wr = w_hit & wr_en;
  assign w_rd = w_hit & rd_en & ~wr_en;

  assign w_mask  = WIDTH'(8'hFF) << {w_lane, 3'b000};
  assign w_wbits = {NBYTES{din}} & w_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tris  <= GPIO_TRIS_RST[WIDTH-1:0];
      r_ogpio <= '0;
    end else if (w_wr) begin
      case (w_reg)
        GPIO_TRIS:  r_tris  <= (r_tris & ~w_mask) | w_wbits;
        GPIO_OGPIO: r_ogpio <= (r_ogpio & ~w_mask) | w_wbits;
        GPIO_OSET:  r_ogpio <= r_ogpio | w_wbits;
        GPIO_OCLR:  r_ogpio <= r_ogpio & ~w_wbits;
        default:    ;
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
    assign port[gi] = r_tris[gi] ? 1'bz : r_ogpio[gi];
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] w_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] r_ie;
  logic [WIDTH-1:0] r_ipol;
  logic [WIDTH-1:0] r_iflag;
  logic             r_irq;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pad   (port),
    .o_s1    (w_s1),
    .o_prev  (w_prev)
  );

  assign w_edge = (r_ipol & w_s1 & ~w_prev) | (~r_ipol & ~w_s1 & w_prev);
  assign w_w1c  = (w_wr && (w_reg == GPIO_IFLAG)) ? w_wbits : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ie    <= '0;
      r_ipol  <= '0;
      r_iflag <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && (w_reg == GPIO_IE)) begin
        r_ie <= (r_ie & ~w_mask) | w_wbits;
      end
      if (w_wr && (w_reg == GPIO_IPOL)) begin
        r_ipol <= (r_ipol & ~w_mask) | w_wbits;
      end
      // A new edge outranks a clear landing on the same bit.
      r_iflag <= (r_iflag & ~w_w1c) | w_edge;
      r_irq   <= |(r_iflag & r_ie);
    end
  end

  assign irq = r_irq;
`else
  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pad   (port),
    .o_s1    (w_s1)
  );

  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_word = '0;
    case (w_reg)
      GPIO_TRIS:  w_rd_word = r_tris;
      GPIO_OGPIO: w_rd_word = r_ogpio;
      GPIO_IGPIO: w_rd_word = w_s1;
`ifdef GPIO_IRQ_EN
      GPIO_IE:    w_rd_word = r_ie;
      GPIO_IPOL:  w_rd_word = r_ipol;
      GPIO_IFLAG: w_rd_word = r_iflag;
`endif
      default:    w_rd_word = '0;
    endcase
  end

  always_comb begin
    w_rd_byte = 8'h00;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_lane == 2'(b)) begin
        w_rd_byte = w_rd_word[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= 8'h00;
    end else if (w_rd) begin
      r_dout <= w_rd_byte;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq (WIDTH=16); reads are checked by a scoreboard monitor.
module tb_gpio_irq;
  import gpio_pkg::*;

  localparam int WIDTH = 16;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       addr    = 8'h00;
  logic [7:0]       din     = 8'h00;
  logic             wr_en   = 1'b0;
  logic             rd_en   = 1'b0;
  wire  [7:0]       dout;
  wire              irq;
  wire  [WIDTH-1:0] port;

  logic [WIDTH-1:0] ext_en  = '0;
  logic [WIDTH-1:0] ext_val = '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
    assign port[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  gpio_irq #(.WIDTH(WIDTH), .ADDR_LSB(0), .BASE_ADDR(8'h80)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .port    (port),
    .irq     (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic [7:0] exp_dout = 8'h00;
  logic       tb_rd_v;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_rd_v <= 1'b0;
    else          tb_rd_v <= rd_en;
  end

  always @(negedge clk) begin
    if (tb_rd_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got a read strobe, expected a queued value");
      end else begin
        check(nm_q.pop_front(), dout, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] ra(input int lane, input gpio_reg_t r);
    return 8'h80 | 8'(lane << 3) | 8'(r);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input int lane, input gpio_reg_t r, input logic [7:0] d);
    addr  = ra(lane, r);
    din   = d;
    wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  // Expected value is queued as the read is issued; the monitor compares later.
  task automatic acc(input logic [7:0] a, input logic [7:0] d, input logic w,
                     input logic r, input logic [7:0] e, input string nm);
    addr  = a;
    din   = d;
    wr_en = w;
    rd_en = r;
    if (r) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
      if (!w) exp_dout = e;
    end
    cyc(1);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic rd(input int lane, input gpio_reg_t r, input logic [7:0] e, input string nm);
    acc(ra(lane, r), 8'h00, 1'b0, 1'b1, e, nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc(2);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    ext_en  = 16'hFFFF;
    ext_val = 16'hC33C;
    reset_n = 1'b1;
    cyc(4);
    check("rst_irq_after", {7'd0, irq}, 8'h00);
    rd(0, GPIO_TRIS, 8'hFF, "rst_tris_l0");
    rd(1, GPIO_TRIS, 8'hFF, "rst_tris_l1");
    rd(0, GPIO_IGPIO, 8'h3C, "rst_hiz_igpio_l0");
    rd(1, GPIO_IGPIO, 8'hC3, "rst_hiz_igpio_l1");

    // Output path and atomic set/clear on lane 1.
    ext_en[15:8] = 8'h00;
    wr(1, GPIO_TRIS, 8'h00);
    wr(1, GPIO_OGPIO, 8'hA5);
    check("port_ogpio", port[15:8], 8'hA5);
    wr(1, GPIO_OSET, 8'h0A);
    check("port_oset", port[15:8], 8'hAF);
    wr(1, GPIO_OCLR, 8'h80);
    check("port_oclr", port[15:8], 8'h2F);
    rd(1, GPIO_OGPIO, 8'h2F, "ogpio_l1");
    rd(1, GPIO_OSET, 8'h00, "oset_reads_zero");
    rd(1, GPIO_OCLR, 8'h00, "oclr_reads_zero");
    rd(1, GPIO_IGPIO, 8'h2F, "igpio_readback_l1");
    rd(0, GPIO_OGPIO, 8'h00, "ogpio_l0_untouched");

    // Input latency: pad 3 rises at the edge right after this point.
    ext_val[7:0] = 8'h00;
    cyc(4);
    ext_val[3] = 1'b1;
    rd(0, GPIO_IGPIO, 8'h00, "igpio_at_k");
    rd(0, GPIO_IGPIO, 8'h00, "igpio_issued_k_stale");
    rd(0, GPIO_IGPIO, 8'h08, "igpio_issued_k1");

`ifdef GPIO_IRQ_EN
    wr(0, GPIO_IE, 8'h08);
    wr(0, GPIO_IPOL, 8'h08);
    ext_val[3] = 1'b0;
    cyc(4);
    wr(0, GPIO_IFLAG, 8'hFF);
    rd(0, GPIO_IFLAG, 8'h00, "iflag_cleared");
    check("irq_idle", {7'd0, irq}, 8'h00);

    ext_val[3] = 1'b1;
    rd(0, GPIO_IFLAG, 8'h00, "iflag_k");
    rd(0, GPIO_IFLAG, 8'h00, "iflag_k1");
    rd(0, GPIO_IFLAG, 8'h00, "iflag_k2_sample");
    check("irq_before_k3", {7'd0, irq}, 8'h00);
    rd(0, GPIO_IFLAG, 8'h08, "iflag_rise");
    check("irq_at_k3", {7'd0, irq}, 8'h01);

    wr(0, GPIO_IFLAG, 8'h08);
    check("irq_hold_after_w1c", {7'd0, irq}, 8'h01);
    cyc(1);
    check("irq_drop_after_w1c", {7'd0, irq}, 8'h00);
    rd(0, GPIO_IFLAG, 8'h00, "iflag_after_w1c");

    ext_val[3] = 1'b0;
    cyc(5);
    rd(0, GPIO_IFLAG, 8'h00, "falling_no_flag");
    check("irq_falling", {7'd0, irq}, 8'h00);

    // Clear lands in the same cycle the rising edge is detected.
    ext_val[3] = 1'b1;
    cyc(2);
    wr(0, GPIO_IFLAG, 8'h08);
    rd(0, GPIO_IFLAG, 8'h08, "set_beats_w1c");
    check("irq_set_beats_w1c", {7'd0, irq}, 8'h01);
    wr(0, GPIO_IFLAG, 8'h08);
    rd(0, GPIO_IFLAG, 8'h00, "iflag_cleared2");

    wr(0, GPIO_IE, 8'h00);
    ext_val[3] = 1'b0;
    cyc(4);
    ext_val[3] = 1'b1;
    cyc(5);
    rd(0, GPIO_IFLAG, 8'h08, "iflag_without_ie");
    check("irq_masked", {7'd0, irq}, 8'h00);
    wr(0, GPIO_IE, 8'h08);
    check("irq_ie_same_cycle", {7'd0, irq}, 8'h00);
    cyc(1);
    check("irq_ie_next_cycle", {7'd0, irq}, 8'h01);
`else
    ext_val[3] = 1'b0;
    cyc(4);
    ext_val[3] = 1'b1;
    cyc(5);
    wr(0, GPIO_IE, 8'h08);
    wr(0, GPIO_IPOL, 8'h08);
    rd(0, GPIO_IFLAG, 8'h00, "noirq_iflag");
    rd(0, GPIO_IE, 8'h00, "noirq_ie");
    rd(0, GPIO_IPOL, 8'h00, "noirq_ipol");
    check("noirq_irq", {7'd0, irq}, 8'h00);
`endif

    // Write and read together: write lands, dout holds.
    acc(ra(1, GPIO_OGPIO), 8'h11, 1'b1, 1'b1, exp_dout, "wr_rd_dout_holds");
    check("wr_rd_port", port[15:8], 8'h11);
    rd(1, GPIO_OGPIO, 8'h11, "wr_rd_write_applied");

    // Accesses outside the 0x80..0x8F window.
    acc(8'h90, 8'h00, 1'b1, 1'b0, 8'h00, "");
    acc(8'h98, 8'h00, 1'b0, 1'b1, exp_dout, "miss_dout_holds");
    acc(8'h00, 8'h00, 1'b0, 1'b1, exp_dout, "miss_low_dout_holds");
    rd(0, GPIO_TRIS, 8'hFF, "miss_no_write");

    // Asynchronous reset in the middle of a write.
    addr  = ra(1, GPIO_OGPIO);
    din   = 8'hFF;
    wr_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 8'h00);
    check("async_rst_irq", {7'd0, irq}, 8'h00);
    exp_dout = 8'h00;
    @(negedge clk);
    wr_en = 1'b0;
    cyc(2);
    ext_en[15:8]  = 8'hFF;
    ext_val[15:8] = 8'h5A;
    reset_n = 1'b1;
    cyc(4);
    rd(1, GPIO_TRIS, 8'hFF, "post_rst_tris");
    rd(1, GPIO_OGPIO, 8'h00, "post_rst_ogpio");
    rd(1, GPIO_IGPIO, 8'h5A, "post_rst_hiz_igpio");
    rd(0, GPIO_IE, 8'h00, "post_rst_ie");
    check("post_rst_irq", {7'd0, irq}, 8'h00);

    cyc(2);
    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
